// File: rtl/gray_encode_arbiter.sv
// gray_encode_arbiter
// Two requesters share one binary-to-Gray encode stage. A round-robin pointer
// breaks ties. The winner's word, either passed through or Gray-encoded, is
// loaded into a single output register together with the winner's ID.
module gray_encode_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_select,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_select,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_id_q,    out_id_d;
    logic             prio_q,      prio_d;

    logic             accept;
    logic             grant_valid;
    logic             grant_id;
    logic             xfer;

    // Reflected Gray code when sel is high, otherwise the word unchanged.
    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b, input logic sel);
        return sel ? (b ^ (b >> 1)) : b;
    endfunction

    // Output register can take a new word when it is empty or is being drained this cycle.
    assign accept = !out_valid_q || out_ready;

    // Round-robin grant: a lone valid requester wins; on a tie the priority pointer decides.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = prio_q;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    // Readys are held low during reset so no word is consumed while the block is being cleared.
    assign req0_ready = accept && grant_valid && !grant_id && !reset;
    assign req1_ready = accept && grant_valid &&  grant_id && !reset;
    assign xfer       = req0_ready || req1_ready;

    // Next state: load on a transfer (also covers drain+load), otherwise drain or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        prio_d      = prio_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_id_d    = grant_id;
            prio_d      = !grant_id;
            out_data_d  = grant_id ? encode(req1_data, req1_select)
                                   : encode(req0_data, req0_select);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending result and restores priority to requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            prio_q      <= prio_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray_encode_arbiter.sv
// Bench for gray_encode_arbiter: a behavioural reference model checked on every
// falling edge, plus directed vectors with hand-computed literal expectations.
module tb_gray_encode_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_select, req0_ready;
    logic [2:0] req0_data;
    logic       req1_valid, req1_select, req1_ready;
    logic [2:0] req1_data;
    logic       out_valid, out_id, out_ready;
    logic [2:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gray_encode_arbiter #(.WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_select(req0_select), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_select(req1_select), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: holds what the output register must contain.
    logic       m_valid;
    logic [2:0] m_data;
    logic       m_id;
    logic       m_prio;

    function automatic logic [2:0] ref_enc(input logic [2:0] b, input logic sel);
        logic [2:0] g;
        g[2] = b[2];
        g[1] = b[2] != b[1];
        g[0] = b[1] != b[0];
        return sel ? g : b;
    endfunction

    // Which requester the rules say is accepted this cycle (-1 for none).
    function automatic int ref_winner();
        if (reset) return -1;
        if (m_valid && !out_ready) return -1;
        if (req0_valid && req1_valid) return m_prio ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        int w;
        if (reset) begin
            m_valid = 1'b0; m_data = 3'd0; m_id = 1'b0; m_prio = 1'b0;
        end else begin
            w = ref_winner();
            if (w == 0) begin
                m_valid = 1'b1; m_id = 1'b0; m_prio = 1'b1;
                m_data = ref_enc(req0_data, req0_select);
            end else if (w == 1) begin
                m_valid = 1'b1; m_id = 1'b1; m_prio = 1'b0;
                m_data = ref_enc(req1_data, req1_select);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Every falling edge: outputs and readys against the model.
    always @(negedge clk) begin
        int w;
        w = ref_winner();
        chk("m_out_valid", out_valid, m_valid);
        chk("m_out_data", out_data, m_data);
        chk("m_out_id", out_id, m_id);
        chk("m_req0_ready", req0_ready, w == 0);
        chk("m_req1_ready", req1_ready, w == 1);
    end

    task automatic drive(input logic v0, input logic [2:0] d0, input logic s0,
                         input logic v1, input logic [2:0] d1, input logic s1, input logic ordy);
        req0_valid = v0; req0_data = d0; req0_select = s0;
        req1_valid = v1; req1_data = d1; req1_select = s1;
        out_ready  = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] gtbl [8];

    initial begin
        gtbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        step(); step();
        reset = 1'b0;
        // Idle after reset.
        step();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_req0_ready", req0_ready, 0);
        chk("idle_req1_ready", req1_ready, 0);
        step();

        // Gray sweep, requester 0.
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 1, 0, 0, 0, 1);
            step();
            chk("gray_data", out_data, gtbl[i]);
            chk("gray_id", out_id, 0);
            chk("gray_valid", out_valid, 1);
        end
        // Pass-through sweep.
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 0, 0, 0, 0, 1);
            step();
            chk("pass_data", out_data, i);
            chk("pass_id", out_id, 0);
        end

        // Asynchronous reset mid-cycle.
        drive(0, 0, 0, 0, 0, 0, 1);
        #3 reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_readys", {req0_ready, req1_ready}, 0);
        step();
        reset = 1'b0;

        // Round-robin, both valid.
        drive(1, 3'b011, 1, 1, 3'b101, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_id", out_id, i % 2);
            chk("rr_data", out_data, (i % 2) ? 3'b101 : 3'b010);
        end

        // Backpressure: last winner was 1, so prio names 0.
        out_ready = 1'b0;
        #1;
        chk("bp_readys", {req0_ready, req1_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 3'b101);
            chk("bp_id", out_id, 1);
            chk("bp_readys_hold", {req0_ready, req1_ready}, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {req0_ready, req1_ready}, 2'b10);
        step();
        chk("bp_release_id", out_id, 0);
        chk("bp_release_data", out_data, 3'b010);

        // Simultaneous drain and load from requester 1.
        drive(0, 0, 0, 1, 3'b111, 1, 1);
        step();
        chk("dl_valid", out_valid, 1);
        chk("dl_data", out_data, 3'b100);
        chk("dl_id", out_id, 1);

        // Plain drain keeps data.
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_data", out_data, 3'b100);

        // Reset during a stall; last transfer by 0 leaves prio at 1 before reset.
        drive(1, 3'b011, 1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("stall_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("stall_rst_valid", out_valid, 0);
        chk("stall_rst_data", out_data, 0);
        step();
        reset = 1'b0;
        drive(1, 3'b001, 0, 1, 3'b110, 0, 1);
        step();
        chk("post_rst_id", out_id, 0);
        chk("post_rst_data", out_data, 3'b001);
        step();
        chk("post_rst_id2", out_id, 1);
        chk("post_rst_data2", out_data, 3'b110);
        drive(0, 0, 0, 0, 0, 0, 1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
